// File: rtl/load_align_unit_pkg.sv
// Shared load opcodes and helpers for the load alignment path.
package load_align_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/load_data_extract.sv
// Selects the addressed byte/half/word (big-endian offsets) and extends it.
module load_data_extract
    import load_align_unit_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    output logic [31:0] o_data,
    output logic        o_misaligned
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

    always_comb begin
        o_data       = '0;
        o_misaligned = 1'b0;
        case (i_opcode)
            OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_data = {24'd0, w_byte};
            OP_LH: begin
                o_misaligned = i_offset[0];
                o_data       = i_offset[0] ? 32'd0 : {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                o_misaligned = i_offset[0];
                o_data       = i_offset[0] ? 32'd0 : {16'd0, w_half};
            end
            OP_LW: begin
                o_misaligned = (i_offset != 2'd0);
                o_data       = (i_offset != 2'd0) ? 32'd0 : i_word;
            end
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; power-of-2 depth.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/load_align_unit.sv
// Partition-filtered load issue, in-order tracking and aligned response queue.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      addr_partition,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_opcode,
    input  logic [31:0]     req_addr,
    input  logic [TAGW-1:0] req_rd,
    output logic            mem_re,
    output logic [29:0]     mem_addr,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_data,
    output logic [TAGW-1:0] resp_rd,
    output logic            resp_misaligned
);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int META_W = 6 + 2 + TAGW;
    localparam int RESP_W = 1 + 32 + TAGW;

    logic              w_accept, w_hit;
    logic [META_W-1:0] w_meta_in, w_meta_out;
    logic              w_meta_empty, w_meta_full;
    logic [CW-1:0]     w_meta_cnt;
    logic [RESP_W-1:0] w_resp_in, w_resp_out;
    logic              w_resp_empty, w_resp_full;
    logic [CW-1:0]     w_resp_cnt;
    logic              w_ret;
    logic              w_resp_pop;
    logic [CW:0]       w_occ;
    logic [5:0]        w_m_op;
    logic [1:0]        w_m_off;
    logic [TAGW-1:0]   w_m_rd;
    logic [31:0]       w_ext_data;
    logic              w_ext_mis;

    // Combined occupancy bounds both queues, so a return always has room.
    assign w_occ     = {1'b0, w_meta_cnt} + {1'b0, w_resp_cnt};
    assign req_ready = rst_n && (w_occ < (CW+1)'(DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_hit     = w_accept && is_load(req_opcode) &&
                       (req_addr[31:28] == addr_partition);

    assign mem_re    = w_hit;
    assign mem_addr  = req_addr[31:2];
    assign w_meta_in = {req_opcode, req_addr[1:0], req_rd};

    // Returns with nothing outstanding are stale and dropped.
    assign w_ret = mem_rvalid && !w_meta_empty;
    assign {w_m_op, w_m_off, w_m_rd} = w_meta_out;

    sync_fifo #(.WIDTH(META_W), .DEPTH(DEPTH)) u_meta (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_hit),
        .i_data  (w_meta_in),
        .i_pop   (w_ret),
        .o_data  (w_meta_out),
        .o_empty (w_meta_empty),
        .o_full  (w_meta_full),
        .o_count (w_meta_cnt)
    );

    load_data_extract u_extract (
        .i_opcode     (w_m_op),
        .i_offset     (w_m_off),
        .i_word       (mem_rdata),
        .o_data       (w_ext_data),
        .o_misaligned (w_ext_mis)
    );

    assign w_resp_in  = {w_ext_mis, w_ext_data, w_m_rd};
    assign resp_valid = !w_resp_empty;
    assign w_resp_pop = resp_valid && resp_ready;

    sync_fifo #(.WIDTH(RESP_W), .DEPTH(DEPTH)) u_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ret),
        .i_data  (w_resp_in),
        .i_pop   (w_resp_pop),
        .o_data  (w_resp_out),
        .o_empty (w_resp_empty),
        .o_full  (w_resp_full),
        .o_count (w_resp_cnt)
    );

    // Outputs read zero whenever nothing is held.
    assign resp_misaligned = resp_valid & w_resp_out[RESP_W-1];
    assign resp_data       = resp_valid ? w_resp_out[TAGW +: 32] : 32'd0;
    assign resp_rd         = resp_valid ? w_resp_out[TAGW-1:0] : '0;

    logic w_unused;
    assign w_unused = w_meta_full ^ w_resp_full;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with hand-computed expectations.
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr_partition;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic        mem_re;
    logic [29:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25, SW = 6'h2B;
    localparam logic [31:0] WORD = 32'h8899AABB;

    always #5 clk = ~clk;

    load_align_unit #(.DEPTH(2), .TAGW(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr_partition  (addr_partition),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_opcode      (req_opcode),
        .req_addr        (req_addr),
        .req_rd          (req_rd),
        .mem_re          (mem_re),
        .mem_addr        (mem_addr),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .resp_misaligned (resp_misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] op, input logic [31:0] a, input logic [4:0] rd, input logic exp_re);
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = a;
        req_rd     = rd;
        #1;
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        chk("mem_re", {31'd0, mem_re}, {31'd0, exp_re});
        if (exp_re) chk("mem_addr", {2'd0, mem_addr}, {2'd0, a[31:2]});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ret(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] d, input logic [4:0] rd, input logic mis);
        resp_ready = 1'b1;
        #1;
        chk({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, ".data"}, resp_data, d);
        chk({tag, ".rd"}, {27'd0, resp_rd}, {27'd0, rd});
        chk({tag, ".mis"}, {31'd0, resp_misaligned}, {31'd0, mis});
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; addr_partition = 4'd1; req_valid = 1'b0; req_opcode = '0;
        req_addr = '0; req_rd = '0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
        #1;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst.mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_data", resp_data, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic signed byte
        load(LB, 32'h1000_0001, 5'd3, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = WORD; #1;
        chk("lb.pre_valid", {31'd0, resp_valid}, 32'd0);
        tick(); mem_rvalid = 1'b0;
        expect_resp("lb", 32'hFFFF_FF99, 5'd3, 1'b0);

        // Unsigned byte / unsigned half, two in flight
        load(LBU, 32'h1000_0003, 5'd4, 1'b1);
        load(LHU, 32'h1000_0000, 5'd5, 1'b1);
        ret(WORD); ret(WORD);
        expect_resp("lbu", 32'h0000_00BB, 5'd4, 1'b0);
        expect_resp("lhu", 32'h0000_8899, 5'd5, 1'b0);
        load(LH, 32'h1000_0002, 5'd6, 1'b1);
        ret(WORD);
        expect_resp("lh", 32'hFFFF_AABB, 5'd6, 1'b0);

        // Word alignment
        load(LW, 32'h1000_0005, 5'd7, 1'b1);
        ret(WORD);
        expect_resp("lw_mis", 32'd0, 5'd7, 1'b1);
        load(LW, 32'h1000_0004, 5'd8, 1'b1);
        ret(WORD);
        expect_resp("lw", WORD, 5'd8, 1'b0);

        // Non-hits: wrong partition and non-load opcode; stale returns ignored
        load(LB, 32'h2000_0000, 5'd9, 1'b0);
        load(SW, 32'h1000_0000, 5'd9, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = 1'b1; mem_rdata = WORD;
            tick();
            if (resp_valid) seen = 1'b1;
        end
        mem_rvalid = 1'b0;
        chk("nohit.resp_valid", {31'd0, seen}, 32'd0);

        // Backpressure with DEPTH=2
        load(LB, 32'h1000_0000, 5'd10, 1'b1);
        load(LBU, 32'h1000_0001, 5'd11, 1'b1);
        req_valid = 1'b1; req_opcode = LHU; req_addr = 32'h1000_0002; req_rd = 5'd12;
        #1;
        chk("bp.stall_ready", {31'd0, req_ready}, 32'd0);
        chk("bp.stall_re", {31'd0, mem_re}, 32'd0);
        ret(WORD); ret(WORD);
        chk("bp.stall_ready2", {31'd0, req_ready}, 32'd0);
        resp_ready = 1'b1; #1;
        chk("bp.first_data", resp_data, 32'hFFFF_FF88);
        chk("bp.first_rd", {27'd0, resp_rd}, 32'd10);
        tick(); resp_ready = 1'b0;
        chk("bp.third_ready", {31'd0, req_ready}, 32'd1);
        chk("bp.third_re", {31'd0, mem_re}, 32'd1);
        tick(); req_valid = 1'b0;
        ret(WORD);
        expect_resp("bp.second", 32'h0000_0099, 5'd11, 1'b0);
        expect_resp("bp.third", 32'h0000_AABB, 5'd12, 1'b0);

        // Reset mid-operation drops held and in-flight loads
        load(LW, 32'h1000_0000, 5'd13, 1'b1);
        load(LB, 32'h1000_0000, 5'd14, 1'b1);
        ret(WORD);
        chk("mrst.held_valid", {31'd0, resp_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mrst.resp_data", resp_data, 32'd0);
        chk("mrst.resp_rd", {27'd0, resp_rd}, 32'd0);
        chk("mrst.req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        ret(WORD);
        chk("mrst.late_rvalid", {31'd0, resp_valid}, 32'd0);
        load(LBU, 32'h1000_0003, 5'd15, 1'b1);
        ret(WORD);
        expect_resp("mrst.next", 32'h0000_00BB, 5'd15, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
